// File: rtl/rope_motion_ctrl.sv
// Per-rope horizontal motion: latches a speed per rope, integrates it once per frame and bounces at the field edges.
// Latency: ROPES cycles per sweep, one rope per cycle; there is no backpressure, and frame pulses that arrive mid-sweep set the sticky overrun flag.
module rope_motion_ctrl #(
  parameter int ROPES   = 6,
  parameter int SPEED_W = 7,
  parameter int X_W     = 11,
  parameter int FRAC_W  = 4,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 600,
  parameter int BOUNCES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic [ROPES*SPEED_W-1:0] X_SPEED,
  output logic [ROPES*X_W-1:0]     ropeX,
  output logic [ROPES-1:0]         ropeDirLeft,
  output logic [ROPES-1:0]         speedReq,
  output logic                     busy,
  output logic                     overrun
);

  localparam int P_W   = X_W + FRAC_W;
  localparam int S_W   = P_W + 1;
  localparam int IDX_W = (ROPES > 1) ? $clog2(ROPES) : 1;

  localparam logic signed [S_W-1:0] POS_MAX   = S_W'(X_MAX * (1 << FRAC_W));
  localparam logic signed [S_W-1:0] POS_MIN   = S_W'(X_MIN * (1 << FRAC_W));
  localparam logic [P_W-1:0]        POS_MAX_U = P_W'(X_MAX * (1 << FRAC_W));
  localparam logic [P_W-1:0]        POS_MIN_U = P_W'(X_MIN * (1 << FRAC_W));
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(ROPES - 1);
  localparam logic [3:0]            LAST_BNC  = 4'(BOUNCES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;

  logic [P_W-1:0]     pos  [ROPES];
  logic [SPEED_W-1:0] spd  [ROPES];
  logic [3:0]         bcnt [ROPES];

  logic [P_W-1:0]     cur_pos, nxt_pos;
  logic [SPEED_W-1:0] cur_spd, nxt_spd, cur_xs;
  logic [3:0]         cur_cnt, nxt_cnt;
  logic               cur_dir, nxt_dir, cur_req, nxt_req, bounce;
  logic signed [S_W-1:0] pos_ext, spd_ext, sum;

  assign busy = (state == SWEEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP && idx != LAST_IDX)
        idx <= idx + 1'b1;
      else
        idx <= '0;
      if (state == SWEEP && startOfFrame)
        overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (startOfFrame) state_nxt = SWEEP;
      SWEEP:   if (idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select the rope being visited this cycle.
  always_comb begin
    cur_pos = '0;
    cur_spd = '0;
    cur_cnt = '0;
    cur_dir = 1'b0;
    cur_req = 1'b0;
    cur_xs  = '0;
    for (int i = 0; i < ROPES; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_pos = pos[i];
        cur_spd = spd[i];
        cur_cnt = bcnt[i];
        cur_dir = ropeDirLeft[i];
        cur_req = speedReq[i];
        cur_xs  = X_SPEED[i*SPEED_W +: SPEED_W];
      end
    end
  end

  // One extra sign bit so overshooting either edge cannot wrap.
  always_comb begin
    pos_ext = {1'b0, cur_pos};
    spd_ext = S_W'(cur_spd);
    sum     = cur_dir ? (pos_ext - spd_ext) : (pos_ext + spd_ext);
    nxt_pos = cur_pos;
    nxt_spd = cur_spd;
    nxt_cnt = cur_cnt;
    nxt_dir = cur_dir;
    nxt_req = cur_req;
    bounce  = 1'b0;
    if (cur_req) begin
      if (cur_xs != '0) begin
        nxt_spd = cur_xs;
        nxt_req = 1'b0;
        nxt_cnt = '0;
      end
    end else if (!cur_dir) begin
      if (sum >= POS_MAX) begin
        nxt_pos = POS_MAX_U;
        nxt_dir = 1'b1;
        bounce  = 1'b1;
      end else begin
        nxt_pos = sum[P_W-1:0];
      end
    end else begin
      if (sum <= POS_MIN) begin
        nxt_pos = POS_MIN_U;
        nxt_dir = 1'b0;
        bounce  = 1'b1;
      end else begin
        nxt_pos = sum[P_W-1:0];
      end
    end
    if (bounce) begin
      if (cur_cnt == LAST_BNC) begin
        nxt_req = 1'b1;
        nxt_spd = '0;
        nxt_cnt = '0;
      end else begin
        nxt_cnt = cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROPES; i++) begin
        pos[i]  <= POS_MIN_U;
        spd[i]  <= '0;
        bcnt[i] <= '0;
      end
      ropeDirLeft <= '0;
      speedReq    <= '1;
    end else if (state == SWEEP) begin
      for (int i = 0; i < ROPES; i++) begin
        if (IDX_W'(i) == idx) begin
          pos[i]         <= nxt_pos;
          spd[i]         <= nxt_spd;
          bcnt[i]        <= nxt_cnt;
          ropeDirLeft[i] <= nxt_dir;
          speedReq[i]    <= nxt_req;
        end
      end
    end
  end

  for (genvar g = 0; g < ROPES; g++) begin : g_x
    assign ropeX[g*X_W +: X_W] = pos[g][P_W-1:FRAC_W];
  end

endmodule
